// File: rtl/hazard_pkg.sv
// Shared widths, bypass encodings and shadow-stage entry type for the hazard unit.
package hazard_pkg;

  localparam int TIME_W = 3;
  localparam int REG_W  = 5;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [TIME_W-1:0] TUSE_NONE = 3'd7;

  typedef struct packed {
    logic [REG_W-1:0]  waddr;
    logic [TIME_W-1:0] tnew;
    logic [REG_W-1:0]  raddr0;
    logic [REG_W-1:0]  raddr1;
  } stage_t;

  // Tnew counts down one per stage and sticks at zero.
  function automatic logic [TIME_W-1:0] tnew_dec(input logic [TIME_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// One consumer operand against one producer stage: stall request and bypass-ready flags.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0]  raddr_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic [TIME_W-1:0] tnew_i,
  input  logic [TIME_W-1:0] tuse_i,
  output logic              need_stall_o,
  output logic              can_fwd_o
);

  logic hit;

  // A nonzero raddr that matches also implies waddr != $0.
  assign hit          = (raddr_i != '0) && (raddr_i == waddr_i);
  assign need_stall_o = hit && (tuse_i != TUSE_NONE) && (tnew_i > tuse_i);
  assign can_fwd_o    = hit && (tnew_i == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and bypass-select generation from a shadow E/M/W pipeline of {waddr, tnew, raddr}.
// Optional HAZARD_PERF_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  d_raddr0,
  input  logic [REG_W-1:0]  d_raddr1,
  input  logic [TIME_W-1:0] d_tuse0,
  input  logic [TIME_W-1:0] d_tuse1,
  input  logic [REG_W-1:0]  d_waddr,
  input  logic [TIME_W-1:0] d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d0,
  output logic [1:0]        fwd_d1,
  output logic [1:0]        fwd_e0,
  output logic [1:0]        fwd_e1,
  output logic [1:0]        fwd_m1
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  stage_t             e_q, e_d;
  logic [REG_W-1:0]   m_waddr_q, m_raddr1_q, w_waddr_q;
  logic [TIME_W-1:0]  m_tnew_q;

  // Producer views, index 0=E, 1=M, 2=W (W result always ready).
  logic [2:0][REG_W-1:0]  st_waddr;
  logic [2:0][TIME_W-1:0] st_tnew;
  assign st_waddr = {w_waddr_q, m_waddr_q, e_q.waddr};
  assign st_tnew  = {{TIME_W{1'b0}}, m_tnew_q, e_q.tnew};

  logic [1:0][REG_W-1:0]  d_raddr, e_raddr;
  logic [1:0][TIME_W-1:0] d_tuse;
  assign d_raddr = {d_raddr1, d_raddr0};
  assign d_tuse  = {d_tuse1, d_tuse0};
  assign e_raddr = {e_q.raddr1, e_q.raddr0};

  logic [1:0][2:0] d_stall, d_fwd;
  logic [1:0][1:0] e_stall, e_fwd;
  logic            m_stall, m_fwd;

  for (genvar op = 0; op < 2; op++) begin : g_op
    for (genvar st = 0; st < 3; st++) begin : g_d
      hazard_match u_d (
        .raddr_i     (d_raddr[op]),
        .waddr_i     (st_waddr[st]),
        .tnew_i      (st_tnew[st]),
        .tuse_i      (d_tuse[op]),
        .need_stall_o(d_stall[op][st]),
        .can_fwd_o   (d_fwd[op][st])
      );
    end
    for (genvar st = 0; st < 2; st++) begin : g_e
      hazard_match u_e (
        .raddr_i     (e_raddr[op]),
        .waddr_i     (st_waddr[st+1]),
        .tnew_i      (st_tnew[st+1]),
        .tuse_i      (TUSE_NONE),
        .need_stall_o(e_stall[op][st]),
        .can_fwd_o   (e_fwd[op][st])
      );
    end
  end

  hazard_match u_m (
    .raddr_i     (m_raddr1_q),
    .waddr_i     (w_waddr_q),
    .tnew_i      ({TIME_W{1'b0}}),
    .tuse_i      (TUSE_NONE),
    .need_stall_o(m_stall),
    .can_fwd_o   (m_fwd)
  );

  // E/M consumers pass TUSE_NONE, so their stall terms are constant 0.
  assign stall = (|d_stall) | (|e_stall) | m_stall;

  logic [1:0][1:0] fwd_d_v, fwd_e_v;
  always_comb begin
    fwd_d_v = '0;
    fwd_e_v = '0;
    for (int op = 0; op < 2; op++) begin
      if      (d_fwd[op][0]) fwd_d_v[op] = FWD_E;
      else if (d_fwd[op][1]) fwd_d_v[op] = FWD_M;
      else if (d_fwd[op][2]) fwd_d_v[op] = FWD_W;
      if      (e_fwd[op][0]) fwd_e_v[op] = FWD_M;
      else if (e_fwd[op][1]) fwd_e_v[op] = FWD_W;
    end
  end

  assign fwd_d0 = fwd_d_v[0];
  assign fwd_d1 = fwd_d_v[1];
  assign fwd_e0 = fwd_e_v[0];
  assign fwd_e1 = fwd_e_v[1];
  assign fwd_m1 = m_fwd ? FWD_W : FWD_RF;

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.waddr  = d_waddr;
      e_d.tnew   = d_tnew;
      e_d.raddr0 = d_raddr0;
      e_d.raddr1 = d_raddr1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q        <= '0;
      m_waddr_q  <= '0;
      m_tnew_q   <= '0;
      m_raddr1_q <= '0;
      w_waddr_q  <= '0;
    end else begin
      e_q        <= e_d;
      m_waddr_q  <= e_q.waddr;
      m_tnew_q   <= tnew_dec(e_q.tnew);
      m_raddr1_q <= e_q.raddr1;
      w_waddr_q  <= m_waddr_q;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed instruction-sequence bench for hazard_ctrl stall and bypass selects.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_raddr0, d_raddr1, d_waddr;
  logic [2:0] d_tuse0, d_tuse1, d_tnew;
  logic       stall;
  logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .d_raddr0(d_raddr0),
    .d_raddr1(d_raddr1),
    .d_tuse0 (d_tuse0),
    .d_tuse1 (d_tuse1),
    .d_waddr (d_waddr),
    .d_tnew  (d_tnew),
    .stall   (stall),
    .fwd_d0  (fwd_d0),
    .fwd_d1  (fwd_d1),
    .fwd_e0  (fwd_e0),
    .fwd_e1  (fwd_e1),
    .fwd_m1  (fwd_m1)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic set_d(input logic [4:0] r0, input logic [4:0] r1,
                       input logic [2:0] t0, input logic [2:0] t1,
                       input logic [4:0] wa, input logic [2:0] tn);
    d_raddr0 = r0; d_raddr1 = r1; d_tuse0 = t0; d_tuse1 = t1;
    d_waddr  = wa; d_tnew   = tn;
    #1;
  endtask

  task automatic nop();      set_d(0, 0, 7, 7, 0, 0); endtask
  task automatic tick();     @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  // addu $1,$4,$5 ; addu $2,$1,$3
  task automatic test_alu_alu();
    do_reset();
    set_d(4, 5, 1, 1, 1, 1);
    tick();
    set_d(1, 3, 1, 1, 2, 1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_alu_stall got=%0d exp=0", stall); end
    checks++;
    if (fwd_d0 !== 2'd0) begin failures++; $display("FAIL alu_alu_fwd_d0 got=%0d exp=0", fwd_d0); end
    tick();
    nop();
    checks++;
    if (fwd_e0 !== 2'd2) begin failures++; $display("FAIL alu_alu_fwd_e0 got=%0d exp=2", fwd_e0); end
    checks++;
    if (fwd_e1 !== 2'd0) begin failures++; $display("FAIL alu_alu_fwd_e1 got=%0d exp=0", fwd_e1); end
  endtask

  // lw $1,0($4) ; addu $2,$1,$3
  task automatic test_load_use();
    do_reset();
    set_d(4, 0, 1, 7, 1, 2);
    tick();
    set_d(1, 3, 1, 1, 2, 1);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL ld_use_stall1 got=%0d exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ld_use_stall2 got=%0d exp=0", stall); end
    checks++;
    if (fwd_e0 !== 2'd0) begin failures++; $display("FAIL ld_use_bubble_fwd_e0 got=%0d exp=0", fwd_e0); end
    tick();
    nop();
    checks++;
    if (fwd_e0 !== 2'd3) begin failures++; $display("FAIL ld_use_fwd_e0 got=%0d exp=3", fwd_e0); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ld_use_stall3 got=%0d exp=0", stall); end
  endtask

  // lw $1,0($4) ; beq $1,$0
  task automatic test_load_branch();
    do_reset();
    set_d(4, 0, 1, 7, 1, 2);
    tick();
    set_d(1, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL ld_br_stall1 got=%0d exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL ld_br_stall2 got=%0d exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ld_br_stall3 got=%0d exp=0", stall); end
    checks++;
    if (fwd_d0 !== 2'd3) begin failures++; $display("FAIL ld_br_fwd_d0 got=%0d exp=3", fwd_d0); end
    checks++;
    if (fwd_d1 !== 2'd0) begin failures++; $display("FAIL ld_br_fwd_d1 got=%0d exp=0", fwd_d1); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd2) begin failures++; $display("FAIL ld_br_cnt got=%0d exp=2", stall_cnt); end
`endif
  endtask

  // lw $1,0($4) ; sw $1,0($2)
  task automatic test_load_store();
    do_reset();
    set_d(4, 0, 1, 7, 1, 2);
    tick();
    set_d(2, 1, 1, 2, 0, 0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ld_st_stall got=%0d exp=0", stall); end
    tick();
    nop();
    checks++;
    if (fwd_e1 !== 2'd0) begin failures++; $display("FAIL ld_st_fwd_e1 got=%0d exp=0", fwd_e1); end
    tick();
    checks++;
    if (fwd_m1 !== 2'd3) begin failures++; $display("FAIL ld_st_fwd_m1 got=%0d exp=3", fwd_m1); end
    tick();
    checks++;
    if (fwd_m1 !== 2'd0) begin failures++; $display("FAIL ld_st_fwd_m1_drain got=%0d exp=0", fwd_m1); end
  endtask

  // lui $1 ; beq $1,$1   then   addu $0,$4,$5 ; beq $0,$0
  task automatic test_ready_and_zero();
    do_reset();
    set_d(0, 0, 7, 7, 1, 0);
    tick();
    set_d(1, 1, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lui_br_stall got=%0d exp=0", stall); end
    checks++;
    if ({fwd_d0, fwd_d1} !== 4'b0101) begin failures++; $display("FAIL lui_br_fwd_d got=%b exp=0101", {fwd_d0, fwd_d1}); end
    do_reset();
    set_d(4, 5, 1, 1, 0, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    checks++;
    if ({stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1} !== 11'd0) begin
      failures++;
      $display("FAIL zero_reg got=%b exp=0", {stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1});
    end
  endtask

  // addu $1 ; lui $1 ; beq $1 : both E and M ready, E wins. Then Tuse=7 vs lw.
  task automatic test_priority_tuse_none();
    do_reset();
    set_d(4, 5, 1, 1, 1, 1);
    tick();
    set_d(0, 0, 7, 7, 1, 0);
    tick();
    set_d(1, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL prio_stall got=%0d exp=0", stall); end
    checks++;
    if (fwd_d0 !== 2'd1) begin failures++; $display("FAIL prio_fwd_d0 got=%0d exp=1", fwd_d0); end
    do_reset();
    set_d(4, 0, 1, 7, 1, 2);
    tick();
    set_d(1, 0, 7, 7, 0, 0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL tuse_none_stall got=%0d exp=0", stall); end
  endtask

  // lw $1 ; beq $1,$0 with reset asserted during the stall
  task automatic test_reset_mid_stall();
    do_reset();
    set_d(4, 0, 1, 7, 1, 2);
    tick();
    set_d(1, 0, 0, 0, 0, 0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_stall got=%0d exp=1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1} !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0", {stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    nop();
    test_reset();
    test_alu_alu();
    test_load_use();
    test_load_branch();
    test_load_store();
    test_ready_and_zero();
    test_priority_tuse_none();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
